// File: rtl/riscv_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// riscv : shared rv32 pipeline types, constants and decode helpers
// Rev 1.1 : decode-stage op classes, opcode constants and imm_gen
// ----------------------------------------------------------------------------
package riscv;

  typedef logic [31:0] pc_t;
  typedef logic [31:0] ir_t;
  typedef logic [31:0] word_t;
  typedef logic [4:0]  reg_t;

  localparam pc_t INIT_PC = 32'h0000_0000;
  localparam ir_t NOP     = 32'h0000_0013;  // addi x0, x0, 0

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    LUI     = 4'd1,
    AUIPC   = 4'd2,
    JAL     = 4'd3,
    JALR    = 4'd4,
    BRANCH  = 4'd5,
    LOAD    = 4'd6,
    STORE   = 4'd7,
    OP_IMM  = 4'd8,
    OP      = 4'd9,
    ILLEGAL = 4'd10
  } op_t;

  typedef logic [4:0] opcode_t;

  localparam opcode_t OPC_LOAD   = 5'b00000;
  localparam opcode_t OPC_OP_IMM = 5'b00100;
  localparam opcode_t OPC_AUIPC  = 5'b00101;
  localparam opcode_t OPC_STORE  = 5'b01000;
  localparam opcode_t OPC_OP     = 5'b01100;
  localparam opcode_t OPC_LUI    = 5'b01101;
  localparam opcode_t OPC_BRANCH = 5'b11000;
  localparam opcode_t OPC_JALR   = 5'b11001;
  localparam opcode_t OPC_JAL    = 5'b11011;

  function automatic op_t op_class(input ir_t ir);
    op_t op;
    op = ILLEGAL;
    if (ir == NOP) begin
      op = OP_NOP;
    end else if (ir[1:0] == 2'b11) begin
      case (ir[6:2])
        OPC_LUI:    op = LUI;
        OPC_AUIPC:  op = AUIPC;
        OPC_JAL:    op = JAL;
        OPC_JALR:   op = JALR;
        OPC_BRANCH: op = BRANCH;
        OPC_LOAD:   op = LOAD;
        OPC_STORE:  op = STORE;
        OPC_OP_IMM: op = OP_IMM;
        OPC_OP:     op = OP;
        default:    op = ILLEGAL;
      endcase
    end
    return op;
  endfunction

  function automatic word_t imm_gen(input ir_t ir, input op_t op);
    word_t imm;
    case (op)
      JALR, LOAD, OP_IMM: imm = {{20{ir[31]}}, ir[31:20]};
      STORE:              imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      BRANCH:             imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      LUI, AUIPC:         imm = {ir[31:12], 12'b0};
      JAL:                imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default:            imm = '0;
    endcase
    return imm;
  endfunction

endpackage
`default_nettype wire

// File: rtl/decode_regfile.sv
`default_nettype none
// ----------------------------------------------------------------------------
// regfile : 32x32 register file, 2 async reads, 1 sync write, x0 hardwired
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
module regfile
  import riscv::*;
(
  input  logic  clk,
  input  logic  we,
  input  reg_t  waddr,
  input  word_t wdata,
  input  reg_t  raddr1,
  output word_t rdata1,
  input  reg_t  raddr2,
  output word_t rdata2
);

  // Entry 0 is never written; reads of x0 are short-circuited below.
  word_t mem [32];

  always_ff @(posedge clk) begin
    if (we && waddr != '0) begin
      mem[waddr] <= wdata;
    end
  end

  // Write-through so a same-cycle writeback is visible to the reader.
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (raddr1 != '0) begin
      rdata1 = (we && waddr == raddr1) ? wdata : mem[raddr1];
    end
    if (raddr2 != '0) begin
      rdata2 = (we && waddr == raddr2) ? wdata : mem[raddr2];
    end
  end

endmodule
`default_nettype wire

// File: rtl/decode.sv
`default_nettype none
// ----------------------------------------------------------------------------
// decode : rv32 decode stage with register read and load-use stall
// Rev 1.0 : initial release (execute-stage rd input is named exe_rd)
// ----------------------------------------------------------------------------
module decode #(
  parameter riscv::pc_t INIT_PC = riscv::INIT_PC
) (
  input  logic         clk,
  input  logic         reset,
  input  riscv::pc_t   pc,
  input  riscv::ir_t   ir,
  input  logic         flush,
  input  logic         ex_load,
  input  riscv::reg_t  exe_rd,
  input  logic         wb_en,
  input  riscv::reg_t  wb_rd,
  input  riscv::word_t wb_data,
  output logic         bubble,
  output logic         ex_valid,
  output riscv::pc_t   ex_pc,
  output riscv::op_t   ex_op,
  output logic [2:0]   ex_funct3,
  output logic         ex_alt,
  output riscv::reg_t  ex_rs1,
  output riscv::reg_t  ex_rs2,
  output riscv::word_t ex_rs1_data,
  output riscv::word_t ex_rs2_data,
  output riscv::word_t ex_imm,
  output riscv::reg_t  ex_rd,
  output logic         ex_illegal
);

  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

  state_t       state;
  riscv::pc_t   hold_pc;
  riscv::ir_t   hold_ir;

  riscv::pc_t   src_pc;
  riscv::ir_t   src_ir;
  riscv::op_t   op;
  logic         uses_rs1;
  logic         uses_rs2;
  riscv::reg_t  rs1;
  riscv::reg_t  rs2;
  riscv::reg_t  rd;
  logic         alt;
  riscv::word_t imm;
  riscv::word_t rs1_data;
  riscv::word_t rs2_data;
  logic         hazard;

  always_comb begin
    src_pc   = (state == STALL) ? hold_pc : pc;
    src_ir   = (state == STALL) ? hold_ir : ir;
    op       = riscv::op_class(src_ir);
    imm      = riscv::imm_gen(src_ir, op);
    uses_rs1 = op inside {riscv::JALR, riscv::BRANCH, riscv::LOAD,
                          riscv::STORE, riscv::OP_IMM, riscv::OP};
    uses_rs2 = op inside {riscv::BRANCH, riscv::STORE, riscv::OP};
    // Unused source fields are zeroed so execute never forwards on them.
    rs1      = uses_rs1 ? src_ir[19:15] : '0;
    rs2      = uses_rs2 ? src_ir[24:20] : '0;
    rd       = (op inside {riscv::OP_NOP, riscv::BRANCH, riscv::STORE, riscv::ILLEGAL})
               ? '0 : src_ir[11:7];
    alt      = 1'b0;
    if (op == riscv::OP) begin
      alt = src_ir[30];
    end else if (op == riscv::OP_IMM && src_ir[14:12] == 3'b101) begin
      alt = src_ir[30];
    end
    // rs1/rs2 are already zero when unused and exe_rd is nonzero here.
    hazard   = (state == RUN) && ex_load && (exe_rd != '0)
               && ((rs1 == exe_rd) || (rs2 == exe_rd));
  end

  regfile u_regfile (
    .clk    (clk),
    .we     (wb_en),
    .waddr  (wb_rd),
    .wdata  (wb_data),
    .raddr1 (rs1),
    .rdata1 (rs1_data),
    .raddr2 (rs2),
    .rdata2 (rs2_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      hold_pc     <= '0;
      hold_ir     <= riscv::NOP;
      bubble      <= 1'b0;
      ex_valid    <= 1'b0;
      ex_pc       <= INIT_PC;
      ex_op       <= riscv::OP_NOP;
      ex_funct3   <= '0;
      ex_alt      <= 1'b0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_rd       <= '0;
      ex_illegal  <= 1'b0;
    end else if (flush) begin
      state    <= RUN;
      bubble   <= 1'b0;
      ex_valid <= 1'b0;
    end else if (hazard) begin
      hold_pc  <= pc;
      hold_ir  <= ir;
      ex_valid <= 1'b0;
      bubble   <= 1'b1;
      state    <= STALL;
    end else begin
      state       <= RUN;
      bubble      <= 1'b0;
      ex_valid    <= (op != riscv::OP_NOP);
      ex_pc       <= src_pc;
      ex_op       <= op;
      ex_funct3   <= src_ir[14:12];
      ex_alt      <= alt;
      ex_rs1      <= rs1;
      ex_rs2      <= rs2;
      ex_rs1_data <= rs1_data;
      ex_rs2_data <= rs2_data;
      ex_imm      <= imm;
      ex_rd       <= rd;
      ex_illegal  <= (op == riscv::ILLEGAL);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_decode.sv
`default_nettype none
// tb_decode : directed plus randomized checks of decode against a behavioural model.
module tb_decode;

  logic        clk = 1'b0;
  logic        reset, flush, ex_load, wb_en;
  logic [31:0] pc, ir, wb_data;
  logic [4:0]  exe_rd, wb_rd;

  logic        bubble, ex_valid, ex_alt, ex_illegal;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  riscv::op_t  ex_op;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode dut (
    .clk(clk), .reset(reset), .pc(pc), .ir(ir), .flush(flush),
    .ex_load(ex_load), .exe_rd(exe_rd), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .bubble(bubble), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_op(ex_op),
    .ex_funct3(ex_funct3), .ex_alt(ex_alt), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rd(ex_rd), .ex_illegal(ex_illegal)
  );

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [3:0]  op;
    logic [2:0]  f3;
    logic        alt;
    logic [4:0]  rs1, rs2;
    logic [31:0] d1, d2, imm;
    logic [4:0]  rd;
    logic        ill;
    logic        bub;
  } exp_t;

  logic [31:0] rf [32];
  bit          m_stall;
  logic [31:0] h_pc, h_ir;
  exp_t        e;

  // Class numbers follow the op_t ordering: 0 NOP .. 9 OP, 10 ILLEGAL.
  function automatic int ref_class(input logic [31:0] x);
    if (x == riscv::NOP) return 0;
    if (x[1:0] != 2'b11) return 10;
    case (x[6:0])
      7'h37: return 1;
      7'h17: return 2;
      7'h6F: return 3;
      7'h67: return 4;
      7'h63: return 5;
      7'h03: return 6;
      7'h23: return 7;
      7'h13: return 8;
      7'h33: return 9;
      default: return 10;
    endcase
  endfunction

  function automatic bit ref_uses1(input int c);
    return (c >= 4 && c <= 9);
  endfunction

  function automatic bit ref_uses2(input int c);
    return (c == 5 || c == 7 || c == 9);
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (wb_en && wb_rd == a) return wb_data;
    return rf[a];
  endfunction

  function automatic exp_t ref_decode(input logic [31:0] p, input logic [31:0] x);
    exp_t o;
    int   c, v;
    o = '0;
    c = ref_class(x);
    v = 0;
    case (c)
      4, 6, 8: v = int'(x[30:20]) - (x[31] ? 2048 : 0);
      7:       v = int'(x[30:25]) * 32 + int'(x[11:7]) - (x[31] ? 2048 : 0);
      5:       v = int'(x[7]) * 2048 + int'(x[30:25]) * 32 + int'(x[11:8]) * 2 - (x[31] ? 4096 : 0);
      1, 2:    v = int'(x & 32'hFFFF_F000);
      3:       v = int'(x[19:12]) * 4096 + int'(x[20]) * 2048 + int'(x[30:21]) * 2
                   - (x[31] ? 1048576 : 0);
      default: v = 0;
    endcase
    o.valid = (c != 0);
    o.pc    = p;
    o.op    = 4'(c);
    o.f3    = x[14:12];
    o.alt   = (c == 9 || (c == 8 && x[14:12] == 3'd5)) ? x[30] : 1'b0;
    o.rs1   = ref_uses1(c) ? x[19:15] : 5'd0;
    o.rs2   = ref_uses2(c) ? x[24:20] : 5'd0;
    o.d1    = ref_read(o.rs1);
    o.d2    = ref_read(o.rs2);
    o.imm   = 32'(v);
    o.rd    = (c == 1 || c == 2 || c == 3 || c == 4 || c == 6 || c == 8 || c == 9) ? x[11:7] : 5'd0;
    o.ill   = (c == 10);
    o.bub   = 1'b0;
    return o;
  endfunction

  function automatic bit ref_hazard(input logic [31:0] x);
    int c;
    c = ref_class(x);
    return ex_load && exe_rd != 5'd0 &&
           ((ref_uses1(c) && x[19:15] == exe_rd) || (ref_uses2(c) && x[24:20] == exe_rd));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    if (reset) begin
      e = '0;
      e.pc = riscv::INIT_PC;
      m_stall = 1'b0;
    end else if (flush) begin
      e.valid = 1'b0;
      e.bub = 1'b0;
      m_stall = 1'b0;
    end else if (!m_stall && ref_hazard(ir)) begin
      e.valid = 1'b0;
      e.bub = 1'b1;
      h_pc = pc;
      h_ir = ir;
      m_stall = 1'b1;
    end else begin
      e = ref_decode(m_stall ? h_pc : pc, m_stall ? h_ir : ir);
      m_stall = 1'b0;
    end
    if (wb_en && wb_rd != 5'd0) rf[wb_rd] = wb_data;
    @(posedge clk);
    #1;
    chk("bubble",   32'(bubble),     32'(e.bub));
    chk("valid",    32'(ex_valid),   32'(e.valid));
    chk("pc",       ex_pc,           e.pc);
    chk("op",       32'(ex_op),      32'(e.op));
    chk("funct3",   32'(ex_funct3),  32'(e.f3));
    chk("alt",      32'(ex_alt),     32'(e.alt));
    chk("rs1",      32'(ex_rs1),     32'(e.rs1));
    chk("rs2",      32'(ex_rs2),     32'(e.rs2));
    chk("rs1_data", ex_rs1_data,     e.d1);
    chk("rs2_data", ex_rs2_data,     e.d2);
    chk("imm",      ex_imm,          e.imm);
    chk("rd",       32'(ex_rd),      32'(e.rd));
    chk("illegal",  32'(ex_illegal), 32'(e.ill));
  endtask

  function automatic logic [4:0] rand_reg();
    return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
  endfunction

  function automatic logic [31:0] rand_ir();
    logic [6:0]  opc [9];
    logic [31:0] r;
    int          k;
    opc = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
    r = $urandom;
    k = $urandom_range(0, 11);
    if (k == 0) return riscv::NOP;
    if (k == 10) return {r[31:7], 7'b0001111};
    if (k == 11) return r;
    return {r[31:25], rand_reg(), rand_reg(), r[14:12], rand_reg(), opc[k-1]};
  endfunction

  initial begin
    reset = 1'b1; flush = 1'b0; ex_load = 1'b0; exe_rd = '0;
    wb_en = 1'b0; wb_rd = '0; wb_data = '0; pc = '0; ir = riscv::NOP;
    m_stall = 1'b0; h_pc = '0; h_ir = '0; e = '0;
    for (int i = 0; i < 32; i++) rf[i] = '0;

    tick(); tick();
    chk("reset_valid", 32'(ex_valid), 32'd0);
    chk("reset_pc", ex_pc, riscv::INIT_PC);
    chk("reset_bubble", 32'(bubble), 32'd0);

    reset = 1'b0;
    for (int i = 1; i < 32; i++) begin
      wb_en = 1'b1; wb_rd = 5'(i); wb_data = $urandom;
      tick();
    end
    wb_en = 1'b0;

    pc = 32'h100; ir = 32'h0050_0093;
    tick();
    chk("addi_valid", 32'(ex_valid), 32'd1);
    chk("addi_op", 32'(ex_op), 32'(riscv::OP_IMM));
    chk("addi_rd", 32'(ex_rd), 32'd1);
    chk("addi_imm", ex_imm, 32'd5);
    chk("addi_rs1_data", ex_rs1_data, 32'd0);
    chk("addi_pc", ex_pc, 32'h100);

    pc = 32'h104; ir = 32'h0020_81B3; wb_en = 1'b1; wb_rd = 5'd2; wb_data = 32'hDEAD_BEEF;
    tick();
    chk("bypass_rs2", ex_rs2_data, 32'hDEAD_BEEF);

    pc = 32'h108; ir = 32'h0000_0033; wb_rd = 5'd0; wb_data = 32'h1234_5678;
    tick();
    chk("x0_bypass", ex_rs1_data, 32'd0);
    wb_en = 1'b0;
    tick();
    chk("x0_read", ex_rs2_data, 32'd0);

    pc = 32'h200; ir = 32'h0010_8133; ex_load = 1'b1; exe_rd = 5'd1;
    tick();
    chk("haz_valid", 32'(ex_valid), 32'd0);
    chk("haz_bubble", 32'(bubble), 32'd1);
    ex_load = 1'b0; pc = 32'h204; ir = riscv::NOP;
    tick();
    chk("reissue_valid", 32'(ex_valid), 32'd1);
    chk("reissue_pc", ex_pc, 32'h200);
    chk("reissue_bubble", 32'(bubble), 32'd0);

    pc = 32'h300; ir = 32'h0010_8133; ex_load = 1'b1; exe_rd = 5'd0;
    tick();
    chk("rd0_bubble", 32'(bubble), 32'd0);
    exe_rd = 5'd1; ir = 32'h0000_A0B7;
    tick();
    chk("lui_bubble", 32'(bubble), 32'd0);
    chk("lui_op", 32'(ex_op), 32'(riscv::LUI));

    ir = 32'h0010_8133; pc = 32'h400;
    tick();
    chk("stall_bubble", 32'(bubble), 32'd1);
    flush = 1'b1; ex_load = 1'b0;
    tick();
    chk("flush_stall_valid", 32'(ex_valid), 32'd0);
    chk("flush_stall_bubble", 32'(bubble), 32'd0);
    flush = 1'b0; ir = riscv::NOP;
    tick();
    chk("held_killed", 32'(ex_valid), 32'd0);

    flush = 1'b1; ex_load = 1'b1; exe_rd = 5'd1; ir = 32'h0010_8133;
    tick();
    chk("flush_haz_bubble", 32'(bubble), 32'd0);
    flush = 1'b0; ex_load = 1'b0; ir = riscv::NOP;
    tick();
    chk("flush_haz_no_stall", 32'(ex_valid), 32'd0);

    pc = 32'h500; ir = 32'hFE00_0EE3;
    tick();
    chk("beq_op", 32'(ex_op), 32'(riscv::BRANCH));
    chk("beq_imm", ex_imm, 32'hFFFF_FFFC);
    chk("beq_rd", 32'(ex_rd), 32'd0);
    ir = 32'h0000_007F;
    tick();
    chk("illegal_flag", 32'(ex_illegal), 32'd1);
    chk("illegal_valid", 32'(ex_valid), 32'd1);

    for (int n = 0; n < 3000; n++) begin
      reset   = ($urandom_range(0, 63) == 0);
      flush   = ($urandom_range(0, 9) == 0);
      ex_load = ($urandom_range(0, 2) == 0);
      exe_rd  = rand_reg();
      wb_en   = ($urandom_range(0, 1) == 0);
      wb_rd   = rand_reg();
      wb_data = $urandom;
      pc      = $urandom & 32'hFFFF_FFFC;
      ir      = rand_ir();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/decode.md
Name: decode

Overview:
Instruction decode stage of the rv32 pipeline, directly downstream of fetch.
- Consumes pc/ir from fetch and reads operands from an internal 32x32 register file.
- Produces a registered decoded bundle for execute and detects load-use hazards.
- On a hazard, stalls fetch via a registered bubble and re-issues the held instruction.

Parameters:
INIT_PC, riscv::INIT_PC, pc value driven on ex_pc at reset.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
pc  in  32  pc of ir (riscv::pc_t)
ir  in  32  instruction from fetch (riscv::ir_t); riscv::NOP means no instruction
flush  in  1  taken jump/branch in execute; kill decode contents
ex_load  in  1  instruction currently in execute is a load
ex_rd  in  5  destination register of the instruction in execute
wb_en  in  1  writeback enable
wb_rd  in  5  writeback register
wb_data  in  32  writeback data
bubble  out  1  registered stall request to fetch
ex_valid  out  1  decoded bundle valid (0 = bubble)
ex_pc  out  32  pc of decoded instruction
ex_op  out  4  riscv::op_t class
ex_funct3  out  3  funct3 field
ex_alt  out  1  ir[30] for OP; for OP_IMM only when funct3=101 (SRAI)
ex_rs1  out  5  rs1 index, for forwarding
ex_rs2  out  5  rs2 index
ex_rs1_data  out  32  register file read of rs1
ex_rs2_data  out  32  register file read of rs2
ex_imm  out  32  sign-extended immediate
ex_rd  out  5  destination; forced to 0 for BRANCH/STORE/ILLEGAL
ex_illegal  out  1  unrecognised opcode or ir[1:0]!=11

Behaviour:
- Reset: ex_valid=0, ex_pc=INIT_PC, ex_op=OP_NOP, all other ex_* = 0, bubble=0, state=RUN. The register file is not cleared, except x0.
- All ex_* outputs are registered. Decode latency is 1 cycle from ir to ex_*.
- Decode source:
  - RUN: pc/ir inputs.
  - STALL: hold_pc/hold_ir.
- Op classes by opcode[6:2]: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP, NOP. ir==riscv::NOP decodes as OP_NOP with ex_valid=0.
- Any other opcode gives ex_op=ILLEGAL, ex_illegal=1, ex_valid=1.
- Immediates (all sign-extended from ir[31]):
  - I type: ir[31:20].
  - S type: {ir[31:25], ir[11:7]}.
  - B type: {ir[31], ir[7], ir[30:25], ir[11:8], 0}.
  - U type: {ir[31:12], 12'b0}.
  - J type: {ir[31], ir[19:12], ir[20], ir[30:21], 0}.
  - OP and NOP: imm=0.
- Hazard (combinational, RUN only): ex_load & ex_rd!=0 & ((uses_rs1 & rs1==ex_rd) | (uses_rs2 & rs2==ex_rd)).
  - uses_rs1: JALR, BRANCH, LOAD, STORE, OP_IMM, OP.
  - uses_rs2: BRANCH, STORE, OP.
- FSM:
  - RUN, hazard, no flush: hold_pc/hold_ir <= pc/ir; ex_valid<=0; bubble<=1; go to STALL.
  - STALL: decode hold_ir and issue it with ex_valid=1; bubble<=0; go to RUN. The ir input is ignored in STALL.
  - Upstream contract: fetch re-presents the successor instruction after bubble falls.
  - Flush, any state: ex_valid<=0, bubble<=0, state<=RUN. Hold contents are discarded. Flush has priority over hazard.
  - Reset has priority over flush. Reset in STALL returns to RUN with reset outputs.
- Register file:
  - 2 asynchronous read ports, 1 synchronous write port.
  - Writes to x0 are ignored; x0 always reads 0.
  - Write-through: if wb_en & wb_rd==rs & rs!=0 in the same cycle, the read returns wb_data.
- ex_rs1 and ex_rs2 are forced to 0 when the field is unused, so no spurious forwarding occurs.

Decomposition:
- riscv package gains:
  - op_t enum (4 bits: OP_NOP=0, LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP, ILLEGAL);
  - opcode_t constants for opcode[6:2];
  - reg_t (logic [4:0]) and word_t (logic [31:0]).
- Existing pc_t, ir_t, NOP and INIT_PC are reused.
- One sub-module, regfile (2R1W, write-through, x0 hardwired), instantiated once.
- Immediate generation is a package function, imm_gen(ir, op).

Test Plan:
- Reset, then ir=0x00500093 (addi x1,x0,5) at pc=0x100 → next cycle: ex_valid=1, ex_op=OP_IMM, ex_rd=1, ex_imm=5, ex_rs1_data=0, ex_pc=0x100, bubble=0.
- wb_en=1, wb_rd=2, wb_data=0xDEADBEEF in the same cycle as ir=0x002081B3 (add x3,x1,x2) → ex_rs2_data=0xDEADBEEF (bypass); wb_rd=0 write → x0 still reads 0.
- ex_load=1, ex_rd=1 with ir=0x00108133 (add x2,x1,x1):
  - cycle+1: ex_valid=0, bubble=1;
  - cycle+2: ex_valid=1 with the same pc, bubble=0.
- Same hazard stimulus but ex_rd=0, or ir=0x0000A0B7 (lui x1 — no rs1) → no bubble.
- Hazard cycle followed by flush=1 in STALL → ex_valid=0, bubble=0, held instruction never issued; flush together with hazard in RUN → no STALL entry.
- ir=0xFE000EE3 (beq x0,x0,-4) → ex_op=BRANCH, ex_imm=0xFFFFFFFC, ex_rd=0. ir=0x0000007F → ex_illegal=1.
